// File: rtl/des_ip_pipe_if.sv
// Handshake bundle for des_ip_pipe: upstream beat (valid/ready/mode/tag/data)
// and downstream beat (valid/ready/tag/data). The DUT uses the slave modport.
interface des_ip_pipe_if #(
    parameter int LANES = 1,
    parameter int TAG_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_mode;
    logic [TAG_W-1:0]       in_tag;
    logic [0:64*LANES-1]    in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [TAG_W-1:0]       out_tag;
    logic [0:64*LANES-1]    out_data;

    modport master (
        output in_valid, in_mode, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_tag, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_tag, out_data
    );
endinterface

// File: rtl/des_ip_pipe.sv
// Elastic multi-lane DES IP / IP^-1 permutation pipeline with tag, flush and
// output block counter. Optional `bypass` input under DES_IP_BYPASS_EN.
module des_ip_pipe #(
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
`ifdef DES_IP_BYPASS_EN
    input  logic            bypass,
`endif
    des_ip_pipe_if.slave    bus,
    output logic [31:0]     blk_count
);
    localparam int DW = 64 * LANES;

    function automatic logic [0:63] ip_fwd(input logic [0:63] x);
        logic [0:63] y;
        y = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                y[8*r+c] = x[8*(7-c) + ((r < 4) ? (2*r + 1) : (2*(r-4)))];
        return y;
    endfunction

    function automatic logic [0:63] ip_inv(input logic [0:63] x);
        logic [0:63] y;
        y = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                y[8*r+c] = x[((c % 2 == 0) ? (32 + 4*c) : (4*(c-1))) + 7 - r];
        return y;
    endfunction

    logic [0:DW-1]      perm_d;
    logic [STAGES-1:0]  load;
    logic               take_out;
    logic [STAGES-1:0]  vld_q, vld_d;
    logic [0:DW-1]      data_q [STAGES];
    logic [0:DW-1]      data_d [STAGES];
    logic [TAG_W-1:0]   tag_q  [STAGES];
    logic [TAG_W-1:0]   tag_d  [STAGES];
    logic [31:0]        blk_count_q, blk_count_d;

    always_comb begin
        perm_d = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef DES_IP_BYPASS_EN
            if (bypass)
                perm_d[64*l +: 64] = bus.in_data[64*l +: 64];
            else
`endif
            if (bus.in_mode)
                perm_d[64*l +: 64] = ip_inv(bus.in_data[64*l +: 64]);
            else
                perm_d[64*l +: 64] = ip_fwd(bus.in_data[64*l +: 64]);
        end
    end

    // A stage may load when empty or when its successor drains it this cycle;
    // the chain runs back from the output so in_ready sees out_ready directly.
    always_comb begin
        take_out = vld_q[STAGES-1] && bus.out_ready;
        load = '0;
        load[STAGES-1] = !vld_q[STAGES-1] || take_out;
        for (int s = STAGES - 2; s >= 0; s--)
            load[s] = !vld_q[s] || load[s+1];
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        tag_d  = tag_q;
        if (load[0]) begin
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                data_d[0] = perm_d;
                tag_d[0]  = bus.in_tag;
            end
        end
        for (int s = 1; s < STAGES; s++) begin
            if (load[s]) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    data_d[s] = data_q[s-1];
                    tag_d[s]  = tag_q[s-1];
                end
            end
        end
        // Flush wins over any load, so a beat offered in the flush cycle is lost.
        if (flush)
            vld_d = '0;
        blk_count_d = blk_count_q;
        if (take_out)
            blk_count_d = blk_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            blk_count_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            blk_count_q <= blk_count_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
    assign blk_count     = blk_count_q;

endmodule

// File: tb/tb_des_ip_pipe.sv
// Directed bench for des_ip_pipe: a 1-lane/2-stage instance and a
// 4-lane/3-stage instance, checked against table-driven FIPS IP models.
module tb_des_ip_pipe;
    localparam int IPT [0:63] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int IPI [0:63] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
    localparam int NRT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic [31:0] cnt_a, cnt_b;
`ifdef DES_IP_BYPASS_EN
    logic bypass_a = 1'b0;
`endif
    int n_checks = 0;
    int n_fail = 0;
    int acnt = 0;
    int bcnt = 0;

    always #5 clk = ~clk;

    des_ip_pipe_if #(.LANES(1), .TAG_W(4)) ifa ();
    des_ip_pipe_if #(.LANES(4), .TAG_W(4)) ifb ();

    des_ip_pipe #(.LANES(1), .STAGES(2), .TAG_W(4)) u_a (
        .clk(clk), .rst(rst), .flush(flush_a),
`ifdef DES_IP_BYPASS_EN
        .bypass(bypass_a),
`endif
        .bus(ifa.slave), .blk_count(cnt_a));

    des_ip_pipe #(.LANES(4), .STAGES(3), .TAG_W(4)) u_b (
        .clk(clk), .rst(rst), .flush(flush_b),
`ifdef DES_IP_BYPASS_EN
        .bypass(1'b0),
`endif
        .bus(ifb.slave), .blk_count(cnt_b));

    function automatic logic [0:63] m_ip(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[IPT[i]-1];
        return y;
    endfunction

    function automatic logic [0:63] m_ipinv(input logic [0:63] x);
        logic [0:63] y;
        for (int i = 0; i < 64; i++) y[i] = x[IPI[i]-1];
        return y;
    endfunction

    function automatic logic [0:255] m_beat4(input logic [0:255] x, input logic md);
        logic [0:255] y;
        for (int l = 0; l < 4; l++)
            y[64*l +: 64] = md ? m_ipinv(x[64*l +: 64]) : m_ip(x[64*l +: 64]);
        return y;
    endfunction

    task automatic idle_inputs();
        ifa.in_valid = 0; ifa.in_mode = 0; ifa.in_tag = '0; ifa.in_data = '0; ifa.out_ready = 1;
        ifb.in_valid = 0; ifb.in_mode = 0; ifb.in_tag = '0; ifb.in_data = '0; ifb.out_ready = 1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 64'h0 || ifa.out_tag !== 4'h0 || cnt_a !== 32'h0) begin
            n_fail++; $display("FAIL reset_a: valid=%b data=%h tag=%h cnt=%h, required all 0", ifa.out_valid, ifa.out_data, ifa.out_tag, cnt_a); end
        n_checks++; if (ifb.out_valid !== 1'b0 || ifb.out_data !== 256'h0 || ifb.out_tag !== 4'h0 || cnt_b !== 32'h0) begin
            n_fail++; $display("FAIL reset_b: valid=%b tag=%h cnt=%h, required all 0", ifb.out_valid, ifb.out_tag, cnt_b); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        n_checks++; if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: a=%b b=%b, required 1", ifa.in_ready, ifb.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic single_beat_a(input string nm, input logic [0:63] din, input logic md,
                                 input logic [3:0] tg, input logic [0:63] dexp);
        ifa.out_ready = 1; ifa.in_valid = 1; ifa.in_data = din; ifa.in_mode = md; ifa.in_tag = tg;
        @(negedge clk);
        n_checks++; if (ifa.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_in_ready: got %b required 1", nm, ifa.in_ready); end
        @(posedge clk); #1 ifa.in_valid = 0; ifa.in_data = '0; ifa.in_tag = '0; ifa.in_mode = ~md;
        @(negedge clk);
        n_checks++; if (ifa.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_early: out_valid=%b required 0 one cycle after accept", nm, ifa.out_valid); end
        @(negedge clk);
        n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== dexp || ifa.out_tag !== tg) begin
            n_fail++; $display("FAIL %s_out: valid=%b data=%h tag=%h required 1 %h %h", nm, ifa.out_valid, ifa.out_data, ifa.out_tag, dexp, tg); end
        acnt++;
        @(negedge clk);
        n_checks++; if (ifa.out_valid !== 1'b0 || cnt_a !== acnt) begin
            n_fail++; $display("FAIL %s_count: valid=%b cnt=%0d required 0 %0d", nm, ifa.out_valid, cnt_a, acnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_ip_single();
        single_beat_a("ip_single", 64'h0123456789ABCDEF, 1'b0, 4'h5, 64'hCC00CCFFF0AAF0AA);
    endtask

    task automatic test_roundtrip();
        logic [0:63] src [NRT];
        logic [0:63] mid [NRT];
        logic [0:63] inb, expv;
        single_beat_a("ipinv_single", 64'hCC00CCFFF0AAF0AA, 1'b1, 4'h3, 64'h0123456789ABCDEF);
        for (int i = 0; i < NRT; i++) src[i] = {$urandom, $urandom};
        for (int ph = 0; ph < 2; ph++) begin
            int sent = 0, got = 0, cyc = 0;
            ifa.out_ready = 1; ifa.in_mode = (ph == 1);
            while (got < NRT && cyc < NRT + 50) begin
                inb = (ph == 0) ? src[(sent < NRT) ? sent : 0] : mid[(sent < NRT) ? sent : 0];
                ifa.in_valid = (sent < NRT); ifa.in_data = inb; ifa.in_tag = sent[3:0];
                @(negedge clk);
                if (ifa.out_valid && ifa.out_ready) begin
                    expv = (ph == 0) ? m_ip(src[got]) : src[got];
                    n_checks++; if (ifa.out_data !== expv) begin
                        n_fail++; $display("FAIL roundtrip_p%0d[%0d]: got %h required %h", ph, got, ifa.out_data, expv); end
                    if (ph == 0) mid[got] = ifa.out_data;
                    got++; acnt++;
                end
                if (ifa.in_valid && ifa.in_ready) sent++;
                @(posedge clk); #1 cyc++;
            end
            ifa.in_valid = 0;
            n_checks++; if (got != NRT) begin
                n_fail++; $display("FAIL roundtrip_timeout_p%0d: got %0d beats required %0d", ph, got, NRT); end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:63] src [8];
        for (int i = 0; i < 8; i++) src[i] = {$urandom, $urandom};
        ifa.out_ready = 1; ifa.in_mode = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            ifa.in_valid = (cyc < 8); ifa.in_data = (cyc < 8) ? src[cyc] : '0; ifa.in_tag = cyc[3:0];
            @(negedge clk);
            n_checks++; if (ifa.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b required 1", cyc, ifa.in_ready); end
            n_checks++; if (ifa.out_valid !== (cyc >= 2 && cyc < 10)) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: got %b required %b", cyc, ifa.out_valid, (cyc >= 2 && cyc < 10)); end
            if (cyc >= 2 && cyc < 10) begin
                acnt++;
                n_checks++; if (ifa.out_data !== m_ip(src[cyc-2]) || ifa.out_tag !== 4'(cyc-2)) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h/%h required %h/%h", cyc, ifa.out_data, ifa.out_tag, m_ip(src[cyc-2]), 4'(cyc-2)); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (cnt_a !== acnt) begin
            n_fail++; $display("FAIL b2b_count: got %0d required %0d", cnt_a, acnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [0:255] src [20];
        logic         md  [20];
        logic [0:255] expv;
        int sent = 0, got = 0, cyc = 0, occ = 0;
        logic exp_rdy;
        for (int i = 0; i < 20; i++) begin
            src[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            md[i]  = i[0];
        end
        while (got < 20 && cyc < 200) begin
            ifb.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            ifb.in_valid  = (sent < 20);
            ifb.in_data   = src[(sent < 20) ? sent : 0];
            ifb.in_mode   = md[(sent < 20) ? sent : 0];
            ifb.in_tag    = sent[3:0];
            @(negedge clk);
            exp_rdy = !(occ == 3 && !ifb.out_ready);
            n_checks++; if (ifb.in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL bp_in_ready[%0d]: got %b required %b (occ %0d)", cyc, ifb.in_ready, exp_rdy, occ); end
            if (ifb.out_valid && ifb.out_ready) begin
                expv = m_beat4(src[got], md[got]);
                n_checks++; if (ifb.out_data !== expv || ifb.out_tag !== got[3:0]) begin
                    n_fail++; $display("FAIL bp_data[%0d]: got %h tag %h required %h tag %h", got, ifb.out_data, ifb.out_tag, expv, got[3:0]); end
                got++; occ--; bcnt++;
            end
            if (ifb.in_valid && ifb.in_ready) begin sent++; occ++; end
            @(posedge clk); #1 cyc++;
        end
        ifb.in_valid = 0; ifb.out_ready = 1;
        @(negedge clk);
        n_checks++; if (got != 20 || cnt_b !== 32'd20) begin
            n_fail++; $display("FAIL bp_count: beats %0d blk_count %0d required 20 20", got, cnt_b); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        ifb.out_ready = 0; ifb.in_mode = 0;
        for (int k = 0; k < 3; k++) begin
            ifb.in_valid = 1; ifb.in_data = {8{k[31:0] + 32'h1111}}; ifb.in_tag = 4'(k);
            @(negedge clk);
            n_checks++; if (ifb.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL flush_fill[%0d]: in_ready %b required 1", k, ifb.in_ready); end
            @(posedge clk); #1;
        end
        flush_b = 1; ifb.in_valid = 1; ifb.in_data = {8{32'hDEADBEEF}}; ifb.in_tag = 4'hF; ifb.out_ready = 1;
        @(negedge clk);
        n_checks++; if (ifb.in_ready !== 1'b1 || ifb.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_cycle: in_ready %b out_valid %b required 1 1", ifb.in_ready, ifb.out_valid); end
        bcnt++;
        @(posedge clk); #1 flush_b = 0; ifb.in_valid = 0; ifb.in_data = '0; ifb.in_tag = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++; if (ifb.out_valid !== 1'b0 || cnt_b !== bcnt) begin
                n_fail++; $display("FAIL flush_after[%0d]: out_valid %b cnt %0d required 0 %0d", k, ifb.out_valid, cnt_b, bcnt); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_multilane();
        logic [0:255] din, dexp;
        din = {64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA, 64'hFFFFFFFF00000000, 64'h8000000000000001};
        dexp = m_beat4(din, 1'b1);
        ifb.out_ready = 1; ifb.in_valid = 1; ifb.in_mode = 1; ifb.in_tag = 4'hA; ifb.in_data = din;
        @(posedge clk); #1 ifb.in_valid = 0; ifb.in_mode = 0; ifb.in_data = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++; if (ifb.out_valid !== (k == 3)) begin
                n_fail++; $display("FAIL ml_latency[%0d]: out_valid %b required %b", k, ifb.out_valid, (k == 3)); end
            if (k != 3) begin @(posedge clk); #1; end
        end
        n_checks++; if (ifb.out_data[64 +: 64] !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL ml_lane1: got %h required 0123456789abcdef", ifb.out_data[64 +: 64]); end
        for (int l = 0; l < 4; l++) begin
            n_checks++; if (ifb.out_data[64*l +: 64] !== dexp[64*l +: 64]) begin
                n_fail++; $display("FAIL ml_lane%0d: got %h required %h", l, ifb.out_data[64*l +: 64], dexp[64*l +: 64]); end
        end
        n_checks++; if (ifb.out_tag !== 4'hA) begin
            n_fail++; $display("FAIL ml_tag: got %h required a", ifb.out_tag); end
        bcnt++;
        @(negedge clk);
        n_checks++; if (cnt_b !== bcnt) begin
            n_fail++; $display("FAIL ml_count: got %0d required %0d", cnt_b, bcnt); end
        @(posedge clk); #1;
    endtask

`ifdef DES_IP_BYPASS_EN
    task automatic test_bypass();
        bypass_a = 1;
        single_beat_a("bypass", 64'h0123456789ABCDEF, 1'b1, 4'h9, 64'h0123456789ABCDEF);
        bypass_a = 0;
    endtask
`endif

    task automatic test_reset_midstream();
        ifa.out_ready = 0; ifb.out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            ifa.in_valid = 1; ifa.in_data = {2{32'hA5A5_0000 + k}}; ifa.in_tag = 4'h7;
            ifb.in_valid = 1; ifb.in_data = {8{32'h5A5A_0000 + k}}; ifb.in_tag = 4'h6;
            @(posedge clk); #1;
        end
        ifa.in_valid = 0; ifb.in_valid = 0;
        @(negedge clk);
        n_checks++; if (ifa.out_valid !== 1'b1 || ifb.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: out_valid a=%b b=%b required 1 1", ifa.out_valid, ifb.out_valid); end
        #2 rst = 1;
        #1;
        n_checks++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 64'h0 || ifa.out_tag !== 4'h0 || cnt_a !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_a: valid %b data %h tag %h cnt %0d required 0", ifa.out_valid, ifa.out_data, ifa.out_tag, cnt_a); end
        n_checks++; if (ifb.out_valid !== 1'b0 || ifb.out_data !== 256'h0 || ifb.out_tag !== 4'h0 || cnt_b !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_b: valid %b tag %h cnt %0d required 0", ifb.out_valid, ifb.out_tag, cnt_b); end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        n_checks++; if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1 || ifb.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_release: in_ready a=%b b=%b out_valid b=%b required 1 1 0", ifa.in_ready, ifb.in_ready, ifb.out_valid); end
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ip_single();
        test_roundtrip();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_multilane();
`ifdef DES_IP_BYPASS_EN
        test_bypass();
`endif
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
